// File: rtl/frogger_game_ctrl_pkg.sv
// rtl/frogger_game_ctrl_pkg.sv - shared states, constants and helpers for the Frogger game-flow controller
package frogger_game_ctrl_pkg;

    localparam int STATE_W            = 3;
    localparam int TIMER_W            = 8;
    localparam int DEF_NUM_LIVES      = 3;
    localparam int DEF_MAX_LEVEL      = 99;
    localparam int DEF_DEATH_FRAMES   = 60;
    localparam int DEF_LEVELUP_FRAMES = 30;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_DYING     = 3'd2,
        ST_LEVEL_UP  = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_e;

    // Thermometer code for the lives LEDs: one lit LED per remaining life.
    function automatic logic [2:0] lives_therm(input logic [1:0] lives);
        logic [2:0] t;
        case (lives)
            2'd3:    t = 3'b111;
            2'd2:    t = 3'b011;
            2'd1:    t = 3'b001;
            default: t = 3'b000;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/frogger_game_ctrl_frame_timer.sv
// rtl/frogger_game_ctrl_frame_timer.sv - loadable frame-tick down-counter with one-cycle done
module frogger_game_ctrl_frame_timer
    import frogger_game_ctrl_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               tick_i,
    input  logic               en_i,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    output logic               done_o
);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    // Load wins over a same-cycle tick, so a tick landing on state entry is not counted.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && tick_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Loaded with N-1, so the tick that arrives at zero is the Nth one.
    assign done_o = en_i && tick_i && !load_i && (cnt_q == '0);

endmodule

// File: rtl/frogger_game_ctrl.sv
// rtl/frogger_game_ctrl.sv - Frogger game-flow FSM owning lives and level counters
module frogger_game_ctrl
    import frogger_game_ctrl_pkg::*;
#(
    parameter int NUM_LIVES      = DEF_NUM_LIVES,
    parameter int MAX_LEVEL      = DEF_MAX_LEVEL,
    parameter int DEATH_FRAMES   = DEF_DEATH_FRAMES,
    parameter int LEVELUP_FRAMES = DEF_LEVELUP_FRAMES
) (
    input  logic               i_Clk,
    input  logic               i_Rst_N,
    input  logic               i_Frame_Tick,
    input  logic               i_Game_Start,
    input  logic               i_Collided,
    input  logic               i_Goal,
    output logic [STATE_W-1:0] o_State,
    output logic               o_Cars_Enable,
    output logic               o_Frog_Reset,
    output logic [6:0]         o_Level,
    output logic [1:0]         o_Lives,
    output logic [2:0]         o_LED_Lives
);

    localparam logic [1:0]         LIVES_INIT   = 2'(NUM_LIVES);
    localparam logic [6:0]         LEVEL_MAX    = 7'(MAX_LEVEL);
    localparam logic [TIMER_W-1:0] DEATH_LOAD   = TIMER_W'(DEATH_FRAMES - 1);
    localparam logic [TIMER_W-1:0] LEVELUP_LOAD = TIMER_W'(LEVELUP_FRAMES - 1);

    state_e             state_q, state_d;
    logic [1:0]         lives_q, lives_d;
    logic [6:0]         level_q, level_d;
    logic [2:0]         led_q;
    logic               cars_en_q;
    logic               frog_rst_q, frog_rst_d;
    logic               start_q, hit_q;
    logic               start_rise, hit_rise;
    logic               timer_en, timer_load, timer_done;
    logic [TIMER_W-1:0] timer_val;

    assign start_rise = i_Game_Start & ~start_q;
    assign hit_rise   = i_Collided & ~hit_q;
    assign timer_en   = (state_q == ST_DYING) || (state_q == ST_LEVEL_UP);

    frogger_game_ctrl_frame_timer u_frame_timer (
        .clk_i      (i_Clk),
        .rst_ni     (i_Rst_N),
        .tick_i     (i_Frame_Tick),
        .en_i       (timer_en),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .done_o     (timer_done)
    );

    // Next-state, counter updates and timer load selection.
    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        level_d    = level_q;
        frog_rst_d = 1'b0;
        timer_load = 1'b0;
        timer_val  = DEATH_LOAD;
        case (state_q)
            ST_IDLE: begin
                lives_d = LIVES_INIT;
                level_d = '0;
                if (start_rise) begin
                    state_d    = ST_PLAY;
                    frog_rst_d = 1'b1;
                end
            end
            ST_PLAY: begin
                // A collision outranks a goal in the same cycle.
                if (hit_rise) begin
                    if (lives_q > 2'd1) begin
                        lives_d    = lives_q - 2'd1;
                        state_d    = ST_DYING;
                        timer_load = 1'b1;
                        timer_val  = DEATH_LOAD;
                    end else begin
                        lives_d = '0;
                        state_d = ST_GAME_OVER;
                    end
                end else if (i_Goal) begin
                    state_d    = ST_LEVEL_UP;
                    timer_load = 1'b1;
                    timer_val  = LEVELUP_LOAD;
                    if (level_q < LEVEL_MAX) begin
                        level_d = level_q + 7'd1;
                    end
                end
            end
            ST_DYING, ST_LEVEL_UP: begin
                if (timer_done) begin
                    state_d    = ST_PLAY;
                    frog_rst_d = 1'b1;
                end
            end
            ST_GAME_OVER: begin
                if (start_rise) begin
                    lives_d    = LIVES_INIT;
                    level_d    = '0;
                    state_d    = ST_PLAY;
                    frog_rst_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                lives_d = LIVES_INIT;
                level_d = '0;
            end
        endcase
    end

    // State, counters, registered outputs and edge-detect history.
    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            state_q    <= ST_IDLE;
            lives_q    <= LIVES_INIT;
            level_q    <= '0;
            led_q      <= lives_therm(LIVES_INIT);
            cars_en_q  <= 1'b0;
            frog_rst_q <= 1'b0;
            start_q    <= 1'b1;
            hit_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            lives_q    <= lives_d;
            level_q    <= level_d;
            led_q      <= lives_therm(lives_d);
            cars_en_q  <= (state_d == ST_PLAY);
            frog_rst_q <= frog_rst_d;
            start_q    <= i_Game_Start;
            hit_q      <= i_Collided;
        end
    end

    assign o_State       = state_q;
    assign o_Cars_Enable = cars_en_q;
    assign o_Frog_Reset  = frog_rst_q;
    assign o_Level       = level_q;
    assign o_Lives       = lives_q;
    assign o_LED_Lives   = led_q;

endmodule
